background_line_fetcher: RTL
============================

Name: background_line_fetcher

Overview:
Reader side of the background map interface. It walks one 120-entry map row per video line, driving the 13-bit map address and capturing the 6-bit entries into a double-buffered line buffer. The pixel pipeline reads the front bank by column while the next row is fetched into the back bank. It sits between the background map ROM and the VGA pixel mux.

Parameters:
COLS, 120, map entries per row (columns)
ROWS, 68, map rows; the valid address range is 0..COLS*ROWS-1
ADDR_W, 13, map address width
DATA_W, 6, map entry width
FILL_DATA, 12, value substituted for absent or out-of-range entries

Ports:
i_clk  input  1  system clock, rising edge
i_rst  input  1  synchronous active-high reset
i_line_start  input  1  one-cycle pulse: swap banks if ready, then fetch row i_line_num
i_line_num  input  7  map row to fetch, sampled on i_line_start
o_address  output  ADDR_W  map address to the background map ROM
i_data  input  DATA_W  map entry, valid one clock after its address is presented
i_rd_col  input  7  pixel-side column read index into the front bank
o_pixel_data  output  DATA_W  front-bank entry, registered
o_busy  output  1  fetch in progress
o_fetch_done  output  1  one-cycle pulse when the back bank is complete
o_front_valid  output  1  front bank holds a completed row
o_underrun  output  1  sticky error flag

Behaviour:
- Reset values:
  - o_address=0, o_busy=0, o_fetch_done=0, o_front_valid=0, o_underrun=0, o_pixel_data=FILL_DATA.
  - State is IDLE and the bank select is 0.
  - Buffer RAM contents are not reset.
- States:
  - IDLE: on i_line_start, go to FETCH.
  - FETCH: issue COLS consecutive addresses, then go to DRAIN.
  - DRAIN: one cycle capturing the last entry, then go to DONE.
  - DONE: back bank is complete; wait for i_line_start.
- On i_line_start:
  - If state==DONE, toggle the bank select (back becomes front) and set o_front_valid=1.
  - In all states, latch row=i_line_num, clear col to 0, and enter FETCH next cycle.
- Address generation:
  - base = row*COLS, computed once at start as (row<<7)-(row<<3) for COLS=120.
  - o_address = base+col, registered; col increments by 1 per FETCH cycle, 0..COLS-1.
- Capture:
  - i_data sampled each cycle is written to back[col_d], where col_d is col delayed one cycle.
  - First write occurs 1 cycle after the first address; last write occurs in DRAIN.
- Timing: o_fetch_done pulses exactly COLS+2 cycles after i_line_start, i.e. 122 cycles for COLS=120.
- o_busy is high in FETCH and DRAIN.
- Row out of range (row>=ROWS): o_address holds 0, the ROM is not used, and every back entry is written FILL_DATA. Timing is unchanged.
- i_line_start while in FETCH or DRAIN:
  - The current fetch is aborted and restarted on the new row.
  - No bank swap occurs; o_front_valid keeps its previous value.
  - o_underrun is set to 1 and stays set until i_rst.
- i_line_start coinciding with the DRAIN-to-DONE transition counts as an abort (underrun).
- Pixel read, 1-cycle latency:
  - o_pixel_data = front[i_rd_col] registered.
  - If i_rd_col>=COLS or o_front_valid==0, o_pixel_data = FILL_DATA.
- Reads and writes never target the same bank, so there is no read/write collision.
- Reset mid-fetch returns to IDLE immediately. The next i_line_start starts a fresh fetch without a swap, since the state is not DONE.

Optional Feature:
BG_FETCH_CHECKSUM_EN
- Defined:
  - Adds output o_line_sum, 13 bits, reset 0.
  - A running sum of the DATA_W entries written during a fetch, cleared at i_line_start.
  - The sum is latched to o_line_sum on the o_fetch_done cycle.
  - FILL_DATA entries are included.
- Undefined: the port is absent and there is no adder logic.

Test Plan:
- Reset, then i_line_start with i_line_num=0 and the ROM model in 1-cycle registered mode -> o_address steps 0..119; o_fetch_done pulses 122 cycles later; o_busy is high for 121 cycles; o_front_valid stays 0.
- Second i_line_start with i_line_num=2 -> swap, o_front_valid=1; reading i_rd_col=0..3 returns 8,10,6,8 one cycle after each index; concurrent o_address steps 240..359.
- Row 10 fetched and swapped -> every column reads 12; i_rd_col=120 -> reads 12 (FILL_DATA).
- i_line_num=70 -> no address activity beyond 0; o_fetch_done still pulses at 122 cycles; after swap, all entries read 12.
- i_line_start reissued 50 cycles into a fetch -> o_underrun=1; o_front_valid unchanged; o_fetch_done pulses 122 cycles after the second pulse; o_underrun is cleared only by i_rst.
- With BG_FETCH_CHECKSUM_EN, fetch row 0 -> o_line_sum=960; fetch row 10 -> o_line_sum=1440.

Source files
------------

// File: rtl/background_line_fetcher.sv
// Background map row fetcher: walks one COLS-entry map row per video line into a
// double-buffered line buffer. Optional macro BG_FETCH_CHECKSUM_EN adds o_line_sum.
module background_line_fetcher #(
    parameter int COLS      = 120,
    parameter int ROWS      = 68,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 6,
    parameter int FILL_DATA = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_line_start,
    input  logic [6:0]        i_line_num,
    output logic [ADDR_W-1:0] o_address,
    input  logic [DATA_W-1:0] i_data,
    input  logic [6:0]        i_rd_col,
    output logic [DATA_W-1:0] o_pixel_data,
    output logic              o_busy,
    output logic              o_fetch_done,
    output logic              o_front_valid,
    output logic              o_underrun
`ifdef BG_FETCH_CHECKSUM_EN
    ,
    output logic [12:0]       o_line_sum
`endif
);

    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [6:0]        COLS_L   = 7'(COLS);
    localparam logic [6:0]        ROWS_L   = 7'(ROWS);
    localparam logic [DATA_W-1:0] FILL     = DATA_W'(FILL_DATA);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [6:0]        col_q, col_d_q;
    logic              wr_vld_q, oor_q, bank_q;
    logic [DATA_W-1:0] mem [2][COLS];
    logic [DATA_W-1:0] wdata;
    logic [13:0]       start_base;
    logic              start_oor, swap, abort;

    // row*120 without a multiplier
    assign start_base = ({7'd0, i_line_num} << 7) - ({7'd0, i_line_num} << 3);
    assign start_oor  = (i_line_num >= ROWS_L);
    assign swap       = i_line_start && (state_q == DONE);
    assign abort      = i_line_start && (state_q == FETCH || state_q == DRAIN);
    assign wdata      = oor_q ? FILL : i_data;
    assign o_busy     = (state_q == FETCH) || (state_q == DRAIN);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (col_q == LAST_COL) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            default: state_d = state_q;
        endcase
        if (i_line_start) state_d = FETCH;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_address     <= '0;
            base_q        <= '0;
            col_q         <= '0;
            col_d_q       <= '0;
            wr_vld_q      <= 1'b0;
            oor_q         <= 1'b0;
            bank_q        <= 1'b0;
            o_fetch_done  <= 1'b0;
            o_front_valid <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            col_d_q      <= col_q;
            // a restart discards the in-flight capture so the new row starts clean
            wr_vld_q     <= (state_q == FETCH) && !i_line_start;
            o_fetch_done <= (state_q == DRAIN) && !i_line_start;
            if (i_line_start) begin
                col_q     <= '0;
                oor_q     <= start_oor;
                base_q    <= start_oor ? '0 : ADDR_W'(start_base);
                o_address <= start_oor ? '0 : ADDR_W'(start_base);
                if (swap) begin
                    bank_q        <= ~bank_q;
                    o_front_valid <= 1'b1;
                end
                if (abort) o_underrun <= 1'b1;
            end else if (state_q == FETCH && col_q != LAST_COL) begin
                col_q <= col_q + 7'd1;
                if (!oor_q) o_address <= base_q + ADDR_W'(col_q) + ADDR_W'(1);
            end
        end
    end

    // back bank is ~bank_q, front is bank_q: reads and writes never collide
    always_ff @(posedge i_clk) begin
        if (wr_vld_q) mem[~bank_q][col_d_q] <= wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)                                   o_pixel_data <= FILL;
        else if (i_rd_col >= COLS_L || !o_front_valid) o_pixel_data <= FILL;
        else                                         o_pixel_data <= mem[bank_q][i_rd_col];
    end

`ifdef BG_FETCH_CHECKSUM_EN
    logic [12:0] sum_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q      <= '0;
            o_line_sum <= '0;
        end else begin
            if (i_line_start)  sum_q <= '0;
            else if (wr_vld_q) sum_q <= sum_q + 13'(wdata);
            // include the final entry being written in DRAIN
            if (state_q == DRAIN && !i_line_start) o_line_sum <= sum_q + 13'(wdata);
        end
    end
`endif

endmodule
